// File: rtl/muntjac_instr_decode_stage.sv
// Registered decode stage between fetch and issue, with a 2-entry output/skid buffer.
// Define MUNTJAC_AMO_EN to make OPCODE_AMO a legal encoding; otherwise AMO decodes illegal.
module muntjac_instr_decode_stage #(
  parameter int unsigned XLEN  = 64,
  parameter int unsigned CNT_W = 16
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              flush_i,
  input  logic              in_valid_i,
  output logic              in_ready_o,
  input  logic [31:0]       in_instr_i,
  input  logic [XLEN-1:0]   in_pc_i,
  output logic              out_valid_o,
  input  logic              out_ready_i,
  output logic [XLEN-1:0]   out_pc_o,
  output logic [6:0]        out_opcode_o,
  output logic [4:0]        out_rd_o,
  output logic [4:0]        out_rs1_o,
  output logic [4:0]        out_rs2_o,
  output logic [2:0]        out_funct3_o,
  output logic [XLEN-1:0]   out_imm_o,
  output logic              out_is_word_o,
  output logic              out_illegal_o,
  input  logic              illegal_cnt_clr_i,
  output logic [CNT_W-1:0]  illegal_cnt_o
);

  localparam logic [6:0] OPC_LOAD      = 7'h03;
  localparam logic [6:0] OPC_MISC_MEM  = 7'h0f;
  localparam logic [6:0] OPC_OP_IMM    = 7'h13;
  localparam logic [6:0] OPC_AUIPC     = 7'h17;
  localparam logic [6:0] OPC_OP_IMM_32 = 7'h1b;
  localparam logic [6:0] OPC_STORE     = 7'h23;
  localparam logic [6:0] OPC_AMO       = 7'h2f;
  localparam logic [6:0] OPC_OP        = 7'h33;
  localparam logic [6:0] OPC_LUI       = 7'h37;
  localparam logic [6:0] OPC_OP_32     = 7'h3b;
  localparam logic [6:0] OPC_BRANCH    = 7'h63;
  localparam logic [6:0] OPC_JALR      = 7'h67;
  localparam logic [6:0] OPC_JAL       = 7'h6f;
  localparam logic [6:0] OPC_SYSTEM    = 7'h73;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [6:0]      opcode;
    logic [4:0]      rd;
    logic [4:0]      rs1;
    logic [4:0]      rs2;
    logic [2:0]      funct3;
    logic [XLEN-1:0] imm;
    logic            is_word;
    logic            illegal;
  } dec_entry_t;

  dec_entry_t       dec_c;
  dec_entry_t       out_q;
  dec_entry_t       skid_q;
  logic             out_valid_q;
  logic             skid_valid_q;
  logic [CNT_W-1:0] illegal_cnt_q;
  logic             accept_c;
  logic             consume_c;
  logic             cnt_inc_c;

  logic [XLEN-1:0] imm_i_c, imm_s_c, imm_b_c, imm_u_c, imm_j_c;

  // Immediate candidates for every format, sign-extended from instr[31].
  assign imm_i_c = XLEN'($signed(in_instr_i[31:20]));
  assign imm_s_c = XLEN'($signed({in_instr_i[31:25], in_instr_i[11:7]}));
  assign imm_b_c = XLEN'($signed({in_instr_i[31], in_instr_i[7], in_instr_i[30:25],
                                  in_instr_i[11:8], 1'b0}));
  assign imm_u_c = XLEN'($signed({in_instr_i[31:12], 12'b0}));
  assign imm_j_c = XLEN'($signed({in_instr_i[31], in_instr_i[19:12], in_instr_i[20],
                                  in_instr_i[30:21], 1'b0}));

  always_comb begin
    dec_c         = '0;
    dec_c.pc      = in_pc_i;
    dec_c.opcode  = in_instr_i[6:0];
    dec_c.rd      = in_instr_i[11:7];
    dec_c.rs1     = in_instr_i[19:15];
    dec_c.rs2     = in_instr_i[24:20];
    dec_c.funct3  = in_instr_i[14:12];
    unique case (in_instr_i[6:0])
      OPC_LOAD, OPC_OP_IMM, OPC_JALR, OPC_MISC_MEM, OPC_SYSTEM: dec_c.imm = imm_i_c;
      OPC_OP_IMM_32: begin
        if (XLEN == 32) begin
          dec_c.illegal = 1'b1;
        end else begin
          dec_c.imm     = imm_i_c;
          dec_c.is_word = 1'b1;
        end
      end
      OPC_STORE:           dec_c.imm = imm_s_c;
      OPC_BRANCH:          dec_c.imm = imm_b_c;
      OPC_LUI, OPC_AUIPC:  dec_c.imm = imm_u_c;
      OPC_JAL:             dec_c.imm = imm_j_c;
      OPC_OP:              dec_c.imm = '0;
      OPC_OP_32: begin
        if (XLEN == 32) dec_c.illegal = 1'b1;
        else            dec_c.is_word = 1'b1;
      end
`ifdef MUNTJAC_AMO_EN
      OPC_AMO:             dec_c.imm = '0;
`else
      OPC_AMO:             dec_c.illegal = 1'b1;
`endif
      default:             dec_c.illegal = 1'b1;
    endcase
    if (in_instr_i[1:0] != 2'b11) dec_c.illegal = 1'b1;
    if (dec_c.illegal) dec_c.imm = '0;
  end

  assign in_ready_o = !skid_valid_q;
  assign accept_c   = in_valid_i && in_ready_o;
  assign consume_c  = out_valid_q && out_ready_i;

  // Output register plus skid: accepted entries land in the skid only when the
  // output register is occupied and not draining this cycle.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      out_q        <= '0;
      skid_q       <= '0;
      out_valid_q  <= 1'b0;
      skid_valid_q <= 1'b0;
    end else if (flush_i) begin
      out_valid_q  <= 1'b0;
      skid_valid_q <= 1'b0;
    end else if (consume_c) begin
      if (skid_valid_q) begin
        out_q        <= skid_q;
        out_valid_q  <= 1'b1;
        skid_valid_q <= 1'b0;
      end else if (accept_c) begin
        out_q       <= dec_c;
        out_valid_q <= 1'b1;
      end else begin
        out_valid_q <= 1'b0;
      end
    end else if (accept_c) begin
      if (!out_valid_q) begin
        out_q       <= dec_c;
        out_valid_q <= 1'b1;
      end else begin
        skid_q       <= dec_c;
        skid_valid_q <= 1'b1;
      end
    end
  end

  // Entries dropped by a same-cycle flush never reach issue, so they are not counted.
  assign cnt_inc_c = accept_c && dec_c.illegal && !flush_i;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      illegal_cnt_q <= '0;
    end else if (illegal_cnt_clr_i) begin
      illegal_cnt_q <= cnt_inc_c ? CNT_W'(1) : '0;
    end else if (cnt_inc_c && (illegal_cnt_q != {CNT_W{1'b1}})) begin
      illegal_cnt_q <= illegal_cnt_q + CNT_W'(1);
    end
  end

  assign out_valid_o   = out_valid_q;
  assign out_pc_o      = out_q.pc;
  assign out_opcode_o  = out_q.opcode;
  assign out_rd_o      = out_q.rd;
  assign out_rs1_o     = out_q.rs1;
  assign out_rs2_o     = out_q.rs2;
  assign out_funct3_o  = out_q.funct3;
  assign out_imm_o     = out_q.imm;
  assign out_is_word_o = out_q.is_word;
  assign out_illegal_o = out_q.illegal;
  assign illegal_cnt_o = illegal_cnt_q;

endmodule

// File: tb/tb_muntjac_instr_decode_stage.sv
// Bench for muntjac_instr_decode_stage: an XLEN=64 and an XLEN=32/CNT_W=2 instance share
// one stimulus stream and are checked against a queue-based reference model.
module tb_muntjac_instr_decode_stage;

  logic        clk = 1'b0;
  logic        rst_ni;
  logic        flush, in_valid, out_ready, clr;
  logic [31:0] in_instr;
  logic [63:0] in_pc;

  logic        rdy64, ov64, word64, ill64;
  logic [63:0] pc64, imm64;
  logic [6:0]  opc64;
  logic [4:0]  rd64, rs164, rs264;
  logic [2:0]  f364;
  logic [15:0] cnt64;

  logic        rdy32, ov32, word32, ill32;
  logic [31:0] pc32, imm32;
  logic [6:0]  opc32;
  logic [4:0]  rd32, rs132, rs232;
  logic [2:0]  f332;
  logic [1:0]  cnt32;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [31:0] ins;
    logic [63:0] pc;
  } ent_t;

  ent_t q[$];
  int   mc64 = 0;
  int   mc32 = 0;

  logic [6:0] opc_tab [0:15] = '{7'h03, 7'h0f, 7'h13, 7'h17, 7'h1b, 7'h23, 7'h2f, 7'h33,
                                 7'h37, 7'h3b, 7'h63, 7'h67, 7'h6f, 7'h73, 7'h07, 7'h53};

  always #5 clk = ~clk;

  muntjac_instr_decode_stage #(.XLEN(64), .CNT_W(16)) u_dut64 (
    .clk_i(clk), .rst_ni(rst_ni), .flush_i(flush),
    .in_valid_i(in_valid), .in_ready_o(rdy64), .in_instr_i(in_instr), .in_pc_i(in_pc),
    .out_valid_o(ov64), .out_ready_i(out_ready), .out_pc_o(pc64), .out_opcode_o(opc64),
    .out_rd_o(rd64), .out_rs1_o(rs164), .out_rs2_o(rs264), .out_funct3_o(f364),
    .out_imm_o(imm64), .out_is_word_o(word64), .out_illegal_o(ill64),
    .illegal_cnt_clr_i(clr), .illegal_cnt_o(cnt64)
  );

  muntjac_instr_decode_stage #(.XLEN(32), .CNT_W(2)) u_dut32 (
    .clk_i(clk), .rst_ni(rst_ni), .flush_i(flush),
    .in_valid_i(in_valid), .in_ready_o(rdy32), .in_instr_i(in_instr), .in_pc_i(in_pc[31:0]),
    .out_valid_o(ov32), .out_ready_i(out_ready), .out_pc_o(pc32), .out_opcode_o(opc32),
    .out_rd_o(rd32), .out_rs1_o(rs132), .out_rs2_o(rs232), .out_funct3_o(f332),
    .out_imm_o(imm32), .out_is_word_o(word32), .out_illegal_o(ill32),
    .illegal_cnt_clr_i(clr), .illegal_cnt_o(cnt32)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic longint sext(input longint v, input int bits);
    longint half;
    half = longint'(1) << (bits - 1);
    return (v >= half) ? v - (half * 2) : v;
  endfunction

  // Reference decode built from the encoding tables with plain arithmetic.
  task automatic ref_decode(input logic [31:0] ins, input int xlen,
                            output logic ill, output logic word, output logic [63:0] imm);
    longint v;
    ill  = 1'b1;
    word = 1'b0;
    v    = 0;
    case (ins[6:0])
      7'h03, 7'h13, 7'h67, 7'h0f, 7'h73: begin
        ill = 1'b0; v = sext(longint'(ins[31:20]), 12);
      end
      7'h1b: if (xlen == 64) begin
        ill = 1'b0; word = 1'b1; v = sext(longint'(ins[31:20]), 12);
      end
      7'h23: begin
        ill = 1'b0; v = sext(longint'(ins[31:25]) * 32 + longint'(ins[11:7]), 12);
      end
      7'h63: begin
        ill = 1'b0;
        v = sext(longint'(ins[31]) * 4096 + longint'(ins[7]) * 2048 +
                 longint'(ins[30:25]) * 32 + longint'(ins[11:8]) * 2, 13);
      end
      7'h37, 7'h17: begin
        ill = 1'b0; v = sext(longint'(ins[31:12]) * 4096, 32);
      end
      7'h6f: begin
        ill = 1'b0;
        v = sext(longint'(ins[31]) * 1048576 + longint'(ins[19:12]) * 4096 +
                 longint'(ins[20]) * 2048 + longint'(ins[30:21]) * 2, 21);
      end
      7'h33: ill = 1'b0;
      7'h3b: if (xlen == 64) begin
        ill = 1'b0; word = 1'b1;
      end
`ifdef MUNTJAC_AMO_EN
      7'h2f: ill = 1'b0;
`endif
      default: ;
    endcase
    imm = ill ? 64'd0 : 64'(v);
  endtask

  function automatic int next_cnt(input int c, input logic cl, input logic inc, input int mx);
    if (cl) return inc ? 1 : 0;
    if (inc && c < mx) return c + 1;
    return c;
  endfunction

  task automatic check_all();
    logic        il, wd;
    logic [63:0] im;
    check("in_ready64", 64'(rdy64), 64'(q.size() < 2));
    check("in_ready32", 64'(rdy32), 64'(q.size() < 2));
    check("out_valid64", 64'(ov64), 64'(q.size() > 0));
    check("out_valid32", 64'(ov32), 64'(q.size() > 0));
    if (q.size() > 0) begin
      ref_decode(q[0].ins, 64, il, wd, im);
      check("pc64", pc64, q[0].pc);
      check("opcode64", 64'(opc64), 64'(q[0].ins[6:0]));
      check("rd64", 64'(rd64), 64'(q[0].ins[11:7]));
      check("rs1_64", 64'(rs164), 64'(q[0].ins[19:15]));
      check("rs2_64", 64'(rs264), 64'(q[0].ins[24:20]));
      check("funct3_64", 64'(f364), 64'(q[0].ins[14:12]));
      check("imm64", imm64, im);
      check("is_word64", 64'(word64), 64'(wd));
      check("illegal64", 64'(ill64), 64'(il));
      ref_decode(q[0].ins, 32, il, wd, im);
      check("pc32", 64'(pc32), 64'(q[0].pc[31:0]));
      check("opcode32", 64'(opc32), 64'(q[0].ins[6:0]));
      check("rd32", 64'(rd32), 64'(q[0].ins[11:7]));
      check("imm32", 64'(imm32), 64'(im[31:0]));
      check("is_word32", 64'(word32), 64'(wd));
      check("illegal32", 64'(ill32), 64'(il));
    end
    check("cnt64", 64'(cnt64), 64'(mc64));
    check("cnt32", 64'(cnt32), 64'(mc32));
  endtask

  // One clock of stimulus, entered and left on a falling edge.
  task automatic step(input logic v, input logic [31:0] ins, input logic [63:0] pc,
                      input logic rdy, input logic fl, input logic cl);
    logic        acc, con, il64, il32, wd;
    logic [63:0] im;
    ent_t        e;
    in_valid = v; in_instr = ins; in_pc = pc; out_ready = rdy; flush = fl; clr = cl;
    acc = v && (q.size() < 2);
    con = (q.size() > 0) && rdy;
    ref_decode(ins, 64, il64, wd, im);
    ref_decode(ins, 32, il32, wd, im);
    @(posedge clk);
    if (con) q.delete(0);
    if (fl) begin
      q.delete();
    end else if (acc) begin
      e.ins = ins; e.pc = pc;
      q.push_back(e);
    end
    mc64 = next_cnt(mc64, cl, acc && !fl && il64, 65535);
    mc32 = next_cnt(mc32, cl, acc && !fl && il32, 3);
    @(negedge clk);
    check_all();
  endtask

  task automatic do_reset();
    rst_ni = 1'b0;
    in_valid = 1'b0; flush = 1'b0; clr = 1'b0; out_ready = 1'b0;
    @(posedge clk);
    @(negedge clk);
    q.delete();
    mc64 = 0;
    mc32 = 0;
    check("rst_out_valid", 64'(ov64), 64'd0);
    check("rst_in_ready", 64'(rdy64), 64'd1);
    check("rst_cnt", 64'(cnt64), 64'd0);
    check("rst_pc", pc64, 64'd0);
    check("rst_imm", imm64, 64'd0);
    check("rst_illegal", 64'(ill64), 64'd0);
    check("rst_out_valid32", 64'(ov32), 64'd0);
    rst_ni = 1'b1;
  endtask

  function automatic logic [31:0] rand_instr();
    logic [31:0] r;
    int          k;
    r = $urandom();
    k = $urandom_range(0, 18);
    if (k < 16) r[6:0] = opc_tab[k];
    return r;
  endfunction

  initial begin
    int   save;
    logic exp_amo;
    rst_ni = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0; clr = 1'b0;
    in_instr = '0; in_pc = '0;
    do_reset();

    // addi x1,x0,-1
    step(1'b1, 32'hfff00093, 64'h8000_1000, 1'b1, 1'b0, 1'b0);
    check("t1_opcode", 64'(opc64), 64'h13);
    check("t1_rd", 64'(rd64), 64'd1);
    check("t1_imm", imm64, 64'hffff_ffff_ffff_ffff);

    // jal x1,8 then beq x0,x0,-4
    step(1'b1, 32'h008000ef, 64'h8000_1004, 1'b1, 1'b0, 1'b0);
    check("t2_jal_opcode", 64'(opc64), 64'h6f);
    check("t2_jal_imm", imm64, 64'd8);
    step(1'b1, 32'hfe000ee3, 64'h8000_1008, 1'b1, 1'b0, 1'b0);
    check("t2_beq_imm", imm64, 64'hffff_ffff_ffff_fffc);

    // addiw is illegal at XLEN=32
    step(1'b1, 32'h0000001b, 64'h8000_100c, 1'b1, 1'b0, 1'b0);
    check("t3_illegal32", 64'(ill32), 64'd1);
    check("t3_word32", 64'(word32), 64'd0);
    check("t3_cnt32", 64'(cnt32), 64'd1);
    check("t3_word64", 64'(word64), 64'd1);
    step(1'b1, 32'h00000000, 64'h8000_1010, 1'b1, 1'b0, 1'b0);
    check("t3_cnt32_b", 64'(cnt32), 64'd2);

    // backpressure: three offered, two held
    step(1'b0, 32'h0, 64'h0, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++)
      step(1'b1, 32'h00a00513 + 32'(i << 20), 64'h9000 + 64'(4 * i), 1'b0, 1'b0, 1'b0);
    check("t4_in_ready", 64'(rdy64), 64'd0);
    check("t4_pc_head", pc64, 64'h9000);
    for (int i = 0; i < 3; i++) step(1'b0, 32'h0, 64'h0, 1'b1, 1'b0, 1'b0);
    check("t4_drained", 64'(ov64), 64'd0);

    // flush with a full buffer and an illegal entry offered
    step(1'b1, 32'h00100093, 64'hA000, 1'b0, 1'b0, 1'b0);
    step(1'b1, 32'h00200093, 64'hA004, 1'b0, 1'b0, 1'b0);
    save = mc64;
    step(1'b1, 32'h00000000, 64'hA008, 1'b0, 1'b1, 1'b0);
    check("t5_out_valid", 64'(ov64), 64'd0);
    check("t5_cnt", 64'(cnt64), 64'(save));
    step(1'b0, 32'h0, 64'h0, 1'b1, 1'b0, 1'b0);
    check("t5_nothing", 64'(ov64), 64'd0);

    // saturation of the 2-bit counter
    step(1'b0, 32'h0, 64'h0, 1'b1, 1'b0, 1'b1);
    for (int i = 0; i < 5; i++) begin
      step(1'b1, 32'h00000000, 64'hB000, 1'b1, 1'b0, 1'b0);
      check("t6_cnt32", 64'(cnt32), 64'((i < 3) ? i + 1 : 3));
    end
    step(1'b1, 32'h00000000, 64'hB004, 1'b1, 1'b0, 1'b1);
    check("t6_clr_inc", 64'(cnt32), 64'd1);
`ifdef MUNTJAC_AMO_EN
    exp_amo = 1'b0;
`else
    exp_amo = 1'b1;
`endif
    step(1'b1, 32'h0000202f, 64'hB008, 1'b1, 1'b0, 1'b0);
    check("t6_amo", 64'(ill64), 64'(exp_amo));

    // random traffic with one mid-stream reset
    for (int i = 0; i < 1500; i++) begin
      if (i == 800) do_reset();
      step($urandom_range(0, 9) < 7, rand_instr(), {$urandom(), $urandom()},
           $urandom_range(0, 9) < 6, $urandom_range(0, 31) == 0, $urandom_range(0, 31) == 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
